dsi_pattern_sequencer: RTL and testbench
========================================

Name: dsi_pattern_sequencer

Overview:
Frame-synchronous test-pattern controller for the dual-pixel DSI video path. It consumes data-enable and vsync from the panel timing generator and selects one of five test patterns. Patterns advance on a debounced push-button or automatically every N frames, and only ever at a frame boundary. It emits two 24-bit pixel lanes (even/odd pixel) registered to the timing.

Parameters:
H_ACTIVE_HALF, 960, active pixel pairs per line (half of panel width)
DEBOUNCE_CYCLES, 500000, cycles key_n_in must be stably low to register one press
CHECKER_SHIFT, 5, log2 checkerboard tile size in pixels
NUM_PATTERNS, 5, pattern count; fixed, not to be overridden

Ports:
lcd_clkin  in  1  pixel-pair clock
rst_n_in  in  1  asynchronous, active-low reset
de_in  in  1  active-high data enable from timing generator
vsync_n_in  in  1  active-low vsync from timing generator
key_n_in  in  1  raw asynchronous push-button, active low
auto_en  in  1  1 = auto-advance after dwell_frames frames
dwell_frames  in  8  frames per pattern in auto mode; 0 = auto never advances
de_out  out  1  de_in delayed 1 cycle, aligned with pixel lanes
pattern_sel  out  3  currently displayed pattern, 0..4
pattern_chg  out  1  one-cycle pulse when pattern_sel changes
frame_cnt  out  16  frames since reset, wraps at 65535->0
lcd_datain  out  24  even pixel {R,G,B}
lcd_datain1  out  24  odd pixel {R,G,B}

Behaviour:
- Reset (async, active low): pattern_sel=0, pattern_chg=0, de_out=0, frame_cnt=0, both lanes=0, FSM=S_IDLE, dwell_cnt=0, step_pending=0, all counters and sync flops cleared. Reset asserted mid-frame clears everything immediately. Output resumes only after the next frame start.
- Frame start (fs):
  - vsync_n_in is registered as vs_d.
  - fs = vs_d & ~vsync_n_in, i.e. a single-cycle pulse on the falling edge.
  - frame_cnt increments on each fs.
- Key path:
  - 2-flop synchroniser, then a debounce counter that counts while the synced key is low and clears when it is high.
  - When the counter reaches DEBOUNCE_CYCLES-1, step_pending is set once. No further step is set until the key has been seen high again.
  - At most one pending step: presses while step_pending=1 are discarded.
- FSM:
  - S_IDLE: lanes forced 0. On fs -> S_SHOW with pattern_sel=0 and dwell_cnt=0.
  - S_SHOW: on fs, advance = step_pending | (auto_en & dwell_frames!=0 & dwell_cnt==dwell_frames-1).
  - If advance: pattern_sel = (pattern_sel==4)?0:pattern_sel+1, dwell_cnt=0, step_pending=0, pattern_chg=1 for that single cycle.
  - Otherwise dwell_cnt increments, saturating at 255.
  - Key step and dwell expiry on the same fs produce exactly one advance.
  - A step_pending that is set on the same cycle as fs is consumed at the next fs.
- pattern_sel never changes except on fs. A mid-frame auto_en or dwell_frames change takes effect at the next fs.
- Counters:
  - x (12-bit) counts de_in-high cycles within a line and clears when de_in=0.
  - y (12-bit) increments on each de_in falling edge and clears on fs.
- Pixel lanes:
  - Registered; latency exactly 1 cycle from de_in. de_out=de_in delayed 1.
  - When de_in=0 the next-cycle lanes are 0.
  - Pixel indices: even pixel p0=2x, odd pixel p1=2x+1.
  - Q=H_ACTIVE_HALF/4.
- Patterns (both lanes unless noted):
  - 0 colorbar: x<Q FF0000; x<2Q 00FF00; x<3Q 0000FF; x<4Q FFFFFF; else 000000.
  - 1 solid white FFFFFF.
  - 2 solid black 000000.
  - 3 gray ramp: lane value {g,g,g} with g=p[7:0] of that lane's pixel index.
  - 4 checkerboard: FFFFFF if ((p>>CHECKER_SHIFT)^(y>>CHECKER_SHIFT))&1, else 000000, per lane.

Decomposition:
- Shared package dsi_pattern_pkg:
  - pattern codes PAT_COLORBAR=0, PAT_WHITE=1, PAT_BLACK=2, PAT_GRAY=3, PAT_CHECKER=4.
  - NUM_PATTERNS.
  - RGB constants RED, GREEN, BLUE, WHITE, BLACK.
- One sub-module: key_debounce (synchroniser, debounce counter, press-once/re-arm logic) emitting a single-cycle press pulse.

Test Plan:
- Reset, then a 960x1200 timing stream, first fs -> pattern_sel=0. Line 0: lcd_datain=FF0000 for x 0..239, 00FF00 for 240..479, 0000FF for 480..719, FFFFFF for 720..959. de_out lags de_in by exactly 1 cycle.
- auto_en=1, dwell_frames=2 -> pattern_sel follows 0,0,1,1,2,2,3,3,4,4,0. pattern_chg is high exactly one cycle at each change, coincident with fs.
- DEBOUNCE_CYCLES=16: key low 10 cycles -> no step. Key low 40 cycles mid-frame -> pattern_sel increments once at the next fs, not before. A second press before that fs -> still a single increment.
- dwell_frames=1, auto_en=1, key press pending at the same fs -> pattern_sel advances by exactly 1.
- pattern 3 -> x=5 gives lcd_datain=0A0A0A, lcd_datain1=0B0B0B. Pattern 4 with CHECKER_SHIFT=5 -> x=16, y=0 gives both lanes FFFFFF; x=16, y=32 gives both lanes 000000.
- Assert rst_n_in mid-line with pattern_sel=3 -> all outputs 0 immediately. After release, lanes stay 0 until the next fs, then pattern_sel=0.

Source files
------------

// File: rtl/dsi_pattern_pkg.sv
// Shared definitions for the DSI test-pattern sequencer: pattern codes,
// pattern count, RGB constants and the sequencer state encoding.
package dsi_pattern_pkg;

  // Fixed number of selectable patterns; pattern_sel wraps after the last one.
  localparam int NUM_PATTERNS = 5;

  localparam logic [2:0] PAT_COLORBAR = 3'd0;
  localparam logic [2:0] PAT_WHITE    = 3'd1;
  localparam logic [2:0] PAT_BLACK    = 3'd2;
  localparam logic [2:0] PAT_GRAY     = 3'd3;
  localparam logic [2:0] PAT_CHECKER  = 3'd4;

  // Pixel colours, {R,G,B}.
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLACK = 24'h000000;

  // S_IDLE: waiting for the first frame start, lanes blanked.
  // S_SHOW: displaying pattern_sel, advancing only at frame starts.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SHOW = 1'b1
  } seq_state_t;

endpackage

// File: rtl/dsi_pattern_sequencer_key_debounce.sv
// Push-button conditioning: two-flop synchroniser, debounce counter and a
// press-once latch that re-arms only after the key has been seen released.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic lcd_clkin,
  input  logic rst_n_in,
  input  logic key_n_in,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          key_meta;
  logic          key_sync;
  logic [CW-1:0] cnt;
  logic          armed;

  // Bring the raw asynchronous key into the pixel clock domain.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key_n_in;
      key_sync <= key_meta;
    end
  end

  // Count stable-low cycles; emit one press per hold, re-arm on release.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt   <= '0;
      armed <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else if (armed) begin
        press <= 1'b1;
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dsi_pattern_sequencer.sv
// Frame-synchronous test-pattern generator for the dual-pixel DSI path.
// Patterns change only at frame start, on a debounced key press or after a
// programmable dwell in auto mode. Two pixel lanes are registered one cycle
// behind de_in.
module dsi_pattern_sequencer
  import dsi_pattern_pkg::*;
#(
  parameter int H_ACTIVE_HALF   = 960,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHECKER_SHIFT   = 5
) (
  input  logic        lcd_clkin,
  input  logic        rst_n_in,
  input  logic        de_in,
  input  logic        vsync_n_in,
  input  logic        key_n_in,
  input  logic        auto_en,
  input  logic [7:0]  dwell_frames,
  output logic        de_out,
  output logic [2:0]  pattern_sel,
  output logic        pattern_chg,
  output logic [15:0] frame_cnt,
  output logic [23:0] lcd_datain,
  output logic [23:0] lcd_datain1
);

  // Colour-bar boundaries in pixel pairs (quarter of the active line each).
  localparam logic [11:0] Q1 = 12'(H_ACTIVE_HALF / 4);
  localparam logic [11:0] Q2 = 12'(2 * (H_ACTIVE_HALF / 4));
  localparam logic [11:0] Q3 = 12'(3 * (H_ACTIVE_HALF / 4));
  localparam logic [11:0] Q4 = 12'(4 * (H_ACTIVE_HALF / 4));
  localparam logic [2:0]  LAST_PAT = 3'(NUM_PATTERNS - 1);

  seq_state_t  state, state_next;
  logic [2:0]  pattern_next;
  logic [7:0]  dwell_cnt, dwell_next;
  logic        chg_next;
  logic        advance;
  logic        vs_d;
  logic        fs;
  logic        press;
  logic        step_pending;
  logic [11:0] x, y;
  logic [11:0] p_even, p_odd;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .lcd_clkin(lcd_clkin),
    .rst_n_in (rst_n_in),
    .key_n_in (key_n_in),
    .press    (press)
  );

  assign fs = vs_d & ~vsync_n_in;

  // Frame-start edge detector and free-running frame counter.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vs_d      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      vs_d <= vsync_n_in;
      if (fs) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Hold at most one key step; a press landing on an advancing fs survives.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      step_pending <= 1'b0;
    end else if (press && !step_pending) begin
      step_pending <= 1'b1;
    end else if (advance) begin
      step_pending <= 1'b0;
    end
  end

  // Sequencer state and pattern registers.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= S_IDLE;
      pattern_sel <= PAT_COLORBAR;
      dwell_cnt   <= '0;
      pattern_chg <= 1'b0;
    end else begin
      state       <= state_next;
      pattern_sel <= pattern_next;
      dwell_cnt   <= dwell_next;
      pattern_chg <= chg_next;
    end
  end

  // Next-state logic: every decision is gated by the frame-start pulse.
  always_comb begin
    state_next   = state;
    pattern_next = pattern_sel;
    dwell_next   = dwell_cnt;
    chg_next     = 1'b0;
    advance      = 1'b0;
    case (state)
      S_IDLE: begin
        if (fs) begin
          state_next   = S_SHOW;
          pattern_next = PAT_COLORBAR;
          dwell_next   = '0;
        end
      end
      S_SHOW: begin
        if (fs) begin
          advance = step_pending |
                    (auto_en & (dwell_frames != 8'd0) &
                     (dwell_cnt == dwell_frames - 8'd1));
          if (advance) begin
            pattern_next = (pattern_sel == LAST_PAT) ? PAT_COLORBAR : pattern_sel + 3'd1;
            dwell_next   = '0;
            chg_next     = 1'b1;
          end else if (dwell_cnt != 8'hFF) begin
            dwell_next = dwell_cnt + 8'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pixel-pair column within the line and line index within the frame.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x      <= '0;
      y      <= '0;
      de_out <= 1'b0;
    end else begin
      de_out <= de_in;
      x      <= de_in ? x + 12'd1 : 12'd0;
      if (fs)                  y <= '0;
      else if (de_out && !de_in) y <= y + 12'd1;
    end
  end

  assign p_even = {x[10:0], 1'b0};
  assign p_odd  = {x[10:0], 1'b1};

  function automatic logic [23:0] pattern_pixel(input logic [2:0]  pat,
                                                input logic [11:0] px,
                                                input logic [11:0] col,
                                                input logic [11:0] row);
    logic [11:0] tile;
    tile = (px >> CHECKER_SHIFT) ^ (row >> CHECKER_SHIFT);
    case (pat)
      PAT_COLORBAR: begin
        if (col < Q1)      pattern_pixel = RED;
        else if (col < Q2) pattern_pixel = GREEN;
        else if (col < Q3) pattern_pixel = BLUE;
        else if (col < Q4) pattern_pixel = WHITE;
        else               pattern_pixel = BLACK;
      end
      PAT_WHITE:   pattern_pixel = WHITE;
      PAT_BLACK:   pattern_pixel = BLACK;
      PAT_GRAY:    pattern_pixel = {px[7:0], px[7:0], px[7:0]};
      PAT_CHECKER: pattern_pixel = tile[0] ? WHITE : BLACK;
      default:     pattern_pixel = BLACK;
    endcase
  endfunction

  // Registered pixel lanes; blank outside active video and before first fs.
  always_ff @(posedge lcd_clkin or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lcd_datain  <= '0;
      lcd_datain1 <= '0;
    end else if (state == S_SHOW && de_in) begin
      lcd_datain  <= pattern_pixel(pattern_sel, p_even, x, y);
      lcd_datain1 <= pattern_pixel(pattern_sel, p_odd, x, y);
    end else begin
      lcd_datain  <= '0;
      lcd_datain1 <= '0;
    end
  end

endmodule

// File: tb/tb_dsi_pattern_sequencer.sv
// Bench for dsi_pattern_sequencer: driven timing stream, key presses and
// randomised mode changes, checked against a frame-level reference model.
module tb_dsi_pattern_sequencer;

  localparam int H  = 960;
  localparam int D  = 16;
  localparam int CS = 5;

  logic        clk;
  logic        rst_n;
  logic        de;
  logic        vsync_n;
  logic        key_n;
  logic        auto_en;
  logic [7:0]  dwell_frames;
  logic        de_out;
  logic [2:0]  pattern_sel;
  logic        pattern_chg;
  logic [15:0] frame_cnt;
  logic [23:0] lcd_datain;
  logic [23:0] lcd_datain1;

  dsi_pattern_sequencer #(
    .H_ACTIVE_HALF  (H),
    .DEBOUNCE_CYCLES(D),
    .CHECKER_SHIFT  (CS)
  ) dut (
    .lcd_clkin   (clk),
    .rst_n_in    (rst_n),
    .de_in       (de),
    .vsync_n_in  (vsync_n),
    .key_n_in    (key_n),
    .auto_en     (auto_en),
    .dwell_frames(dwell_frames),
    .de_out      (de_out),
    .pattern_sel (pattern_sel),
    .pattern_chg (pattern_chg),
    .frame_cnt   (frame_cnt),
    .lcd_datain  (lcd_datain),
    .lcd_datain1 (lcd_datain1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_frames;
  bit m_shown;
  int m_pat;
  int m_on_pat;
  bit m_pend;
  bit m_chg;

  task automatic model_reset();
    m_frames = 0; m_shown = 0; m_pat = 0; m_on_pat = 0; m_pend = 0; m_chg = 0;
  endtask

  task automatic model_fs();
    bit adv;
    m_frames = (m_frames + 1) % 65536;
    m_chg = 0;
    if (!m_shown) begin
      m_shown = 1; m_pat = 0; m_on_pat = 0;
    end else begin
      adv = m_pend || (auto_en && dwell_frames != 0 && m_on_pat + 1 == int'(dwell_frames));
      if (adv) begin
        m_pat = (m_pat + 1) % 5; m_on_pat = 0; m_pend = 0; m_chg = 1;
      end else begin
        m_on_pat++;
      end
    end
  endtask

  function automatic logic [23:0] pix(input int pat, input int p, input int xx, input int yy);
    int q;
    logic [7:0] g;
    q = H / 4;
    g = 8'(p % 256);
    case (pat)
      0: begin
        if (xx < q)          return 24'hFF0000;
        else if (xx < 2 * q) return 24'h00FF00;
        else if (xx < 3 * q) return 24'h0000FF;
        else if (xx < 4 * q) return 24'hFFFFFF;
        else                 return 24'h000000;
      end
      1: return 24'hFFFFFF;
      2: return 24'h000000;
      3: return {g, g, g};
      default: return ((((p >> CS) ^ (yy >> CS)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // ---------------- output monitor ----------------
  logic        mon_de;
  logic        mon_rst;
  logic [47:0] mon_e;
  always @(posedge clk) begin
    mon_de  = de;
    mon_rst = rst_n;
    #1;
    if (mon_rst && rst_n) begin
      check("de_out", de_out, mon_de);
      if (mon_de) begin
        check("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("lane_even", lcd_datain, mon_e[47:24]);
          check("lane_odd", lcd_datain1, mon_e[23:0]);
        end
      end else begin
        check("lane_blank", {lcd_datain, lcd_datain1}, 48'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      de = 1'b0;
    end
  endtask

  task automatic drive_line(input int len, input int yy);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      de = 1'b1;
      exp_q.push_back(m_shown ? {pix(m_pat, 2 * i, i, yy), pix(m_pat, 2 * i + 1, i, yy)} : 48'h0);
    end
    idle(3);
  endtask

  task automatic do_fs();
    @(negedge clk);
    check("sel_hold", pattern_sel, 64'(m_pat));
    vsync_n = 1'b0;
    model_fs();
    @(posedge clk); #1;
    check("pattern_sel", pattern_sel, 64'(m_pat));
    check("pattern_chg", pattern_chg, 64'(m_chg));
    check("frame_cnt", frame_cnt, 64'(m_frames));
    @(negedge clk);
    @(posedge clk); #1;
    check("chg_pulse_end", pattern_chg, 0);
    @(negedge clk);
    vsync_n = 1'b1;
    idle(2);
  endtask

  task automatic do_frame(input int nlines, input int len);
    do_fs();
    for (int l = 0; l < nlines; l++) drive_line(len, l);
    idle(2);
  endtask

  task automatic press_key(input int n);
    @(negedge clk);
    key_n = 1'b0;
    repeat (n) @(negedge clk);
    key_n = 1'b1;
    idle(6);
    if (n >= D && !m_pend) m_pend = 1;
    check("sel_hold_key", pattern_sel, 64'(m_pat));
  endtask

  task automatic goto_pattern(input int target);
    auto_en = 1'b0;
    for (int k = 0; k < 6 && m_pat != target; k++) begin
      press_key(30);
      do_frame(1, 6);
    end
  endtask

  // ---------------- main sequence ----------------
  int auto_tbl[10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0};

  initial begin
    rst_n = 1'b0; de = 1'b0; vsync_n = 1'b1; key_n = 1'b1;
    auto_en = 1'b0; dwell_frames = 8'd0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_sel", pattern_sel, 0);
    check("rst_chg", pattern_chg, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_lanes", {lcd_datain, lcd_datain1}, 48'h0);
    check("rst_de_out", de_out, 0);
    rst_n = 1'b1;
    idle(3);

    // Active video before the first frame start stays blank.
    drive_line(6, 0);

    // First frame: colour bars across a full line plus a few pairs past it.
    do_fs();
    drive_line(H + 4, 0);
    drive_line(10, 1);
    idle(2);

    // Auto mode, two frames per pattern.
    auto_en = 1'b1; dwell_frames = 8'd2;
    for (int i = 0; i < 10; i++) begin
      do_frame(1, 5);
      check("auto_seq", pattern_sel, 64'(auto_tbl[i]));
    end
    auto_en = 1'b0;

    // Short press ignored; long press and a second press give one step.
    press_key(10);
    do_frame(1, 5);
    press_key(40);
    press_key(40);
    do_frame(1, 5);
    do_frame(1, 5);

    // Pending key and dwell expiry on the same frame start.
    auto_en = 1'b1; dwell_frames = 8'd1;
    press_key(40);
    do_frame(1, 5);
    auto_en = 1'b0;
    do_frame(1, 5);

    // Gray ramp, then checkerboard across two tile rows.
    goto_pattern(3);
    check("reach_gray", pattern_sel, 3);
    do_frame(1, 20);
    goto_pattern(4);
    check("reach_checker", pattern_sel, 4);
    do_frame(34, 20);

    // Randomised modes, dwell values, line shapes and key presses.
    for (int f = 0; f < 25; f++) begin
      auto_en      = 1'($urandom_range(0, 1));
      dwell_frames = 8'($urandom_range(0, 3));
      do_frame($urandom_range(1, 3), $urandom_range(4, 70));
      if ($urandom_range(0, 2) == 0)
        press_key(($urandom_range(0, 1) == 1) ? $urandom_range(2, 12) : $urandom_range(20, 50));
    end

    // Reset mid-line while showing the gray ramp.
    goto_pattern(3);
    do_fs();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      de = 1'b1;
      exp_q.push_back({pix(3, 2 * i, i, 0), pix(3, 2 * i + 1, i, 0)});
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_lanes", {lcd_datain, lcd_datain1}, 48'h0);
    check("mid_rst_de_out", de_out, 0);
    check("mid_rst_sel", pattern_sel, 0);
    check("mid_rst_chg", pattern_chg, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_q_drained", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    de = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    drive_line(12, 0);
    do_frame(1, 250);

    idle(4);
    check("exp_q_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
